// File: rtl/sr_latch_driver.sv
// sr_latch_driver: clocked command front-end for an SR latch.
// Turns single set/reset requests into width-controlled, mutually exclusive
// s or r pulses, then watches the latch q feedback and reports done or err.
// Optional build macro: SR_SKIP_REDUNDANT_EN. When defined, a command whose
// target value already shows on q_fb completes immediately without a pulse.
module sr_latch_driver #(
    parameter int PULSE_W = 2,  // cycles s or r is held high per command
    parameter int GAP_W   = 1,  // idle cycles after the pulse before checking
    parameter int TIMEOUT = 4,  // q_fb samples taken before giving up
    parameter int CNT_W   = 4   // counter width
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req_valid,
    input  logic req_op,
    output logic req_ready,
    output logic s,
    output logic r,
    input  logic q_fb,
    output logic busy,
    output logic done,
    output logic err
);

    // Parameter sanity: a bad configuration stops elaboration.
    localparam int MAX_CNT = (PULSE_W > GAP_W)
                           ? ((PULSE_W > TIMEOUT) ? PULSE_W : TIMEOUT)
                           : ((GAP_W > TIMEOUT) ? GAP_W : TIMEOUT);

    if (PULSE_W < 1) begin : g_bad_pulse
        $error("sr_latch_driver: PULSE_W must be at least 1");
    end
    if (GAP_W < 0) begin : g_bad_gap
        $error("sr_latch_driver: GAP_W must not be negative");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("sr_latch_driver: TIMEOUT must be at least 1");
    end
    if (CNT_W < 1 || MAX_CNT > (1 << CNT_W)) begin : g_bad_cnt
        $error("sr_latch_driver: CNT_W too small for the configured counts");
    end

    // Counter reload values. Every state counts down to zero, so a state that
    // lasts N cycles loads N-1. The first q_fb sample is taken on the edge that
    // leaves the pulse/gap phase, so CHECK only has TIMEOUT-1 samples left.
    localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_W - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'((GAP_W > 0) ? GAP_W - 1 : 0);
    localparam logic [CNT_W-1:0] CHK_LOAD   = CNT_W'((TIMEOUT > 1) ? TIMEOUT - 2 : 0);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO   = '0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2,
        CHECK = 2'd3
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             op;

    logic cnt_zero;
    logic check_now;
    logic last_try;
    logic match;
    logic skip;

    assign cnt_zero = (cnt == CNT_ZERO);
    assign match    = (q_fb == op);

    // A q_fb sample is taken on the last gap edge (or the last pulse edge when
    // there is no gap) and on every CHECK edge; this keeps done/err registered
    // while still landing in cycle E0+PULSE_W+GAP_W+1 for an ideal latch.
    assign check_now = ((state == GAP) && cnt_zero)
                    || ((state == PULSE) && cnt_zero && (GAP_W == 0))
                    || (state == CHECK);

    // Outside CHECK the sample being taken is the first one.
    assign last_try = (state == CHECK) ? cnt_zero : (TIMEOUT == 1);

`ifdef SR_SKIP_REDUNDANT_EN
    // The latch already holds the requested value: nothing to drive.
    assign skip = (q_fb == req_op);
`else
    assign skip = 1'b0;
`endif

    // Command FSM with registered latch drives and status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= CNT_ZERO;
            op        <= 1'b0;
            s         <= 1'b0;
            r         <= 1'b0;
            busy      <= 1'b0;
            req_ready <= 1'b1;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;

            case (state)
                IDLE: begin
                    if (req_valid) begin
                        op <= req_op;
                        if (skip) begin
                            done <= 1'b1;
                        end else begin
                            state     <= PULSE;
                            cnt       <= PULSE_LOAD;
                            s         <= req_op;
                            r         <= ~req_op;
                            busy      <= 1'b1;
                            req_ready <= 1'b0;
                        end
                    end
                end

                PULSE: begin
                    if (!cnt_zero) begin
                        cnt <= cnt - CNT_ONE;
                    end else begin
                        s <= 1'b0;
                        r <= 1'b0;
                        if (GAP_W > 0) begin
                            state <= GAP;
                            cnt   <= GAP_LOAD;
                        end
                    end
                end

                GAP: begin
                    if (!cnt_zero) begin
                        cnt <= cnt - CNT_ONE;
                    end
                end

                CHECK: begin
                    s <= 1'b0;
                    r <= 1'b0;
                end

                default: begin
                    state     <= IDLE;
                    cnt       <= CNT_ZERO;
                    s         <= 1'b0;
                    r         <= 1'b0;
                    busy      <= 1'b0;
                    req_ready <= 1'b1;
                end
            endcase

            // Feedback evaluation overrides the sequencing above when a sample
            // is due: finish on a match, give up on the last sample, else wait.
            if (check_now) begin
                if (match) begin
                    done      <= 1'b1;
                    state     <= IDLE;
                    cnt       <= CNT_ZERO;
                    busy      <= 1'b0;
                    req_ready <= 1'b1;
                end else if (last_try) begin
                    err       <= 1'b1;
                    state     <= IDLE;
                    cnt       <= CNT_ZERO;
                    busy      <= 1'b0;
                    req_ready <= 1'b1;
                end else if (state == CHECK) begin
                    cnt <= cnt - CNT_ONE;
                end else begin
                    state <= CHECK;
                    cnt   <= CHK_LOAD;
                end
            end
        end
    end

    // The forbidden latch input and a simultaneous done/err must never occur.
    a_no_forbidden: assert property (@(posedge clk) !(s && r));
    a_done_err_excl: assert property (@(posedge clk) !(done && err));

endmodule

// File: tb/tb_sr_latch_driver.sv
// tb_sr_latch_driver: directed bench for sr_latch_driver with an ideal SR
// latch model closing the s/r -> q_fb loop. Outputs are sampled on negedge.
module tb_sr_latch_driver;

    logic clk = 1'b0;
    logic rst_n;
    logic req_valid;
    logic req_op;
    logic req_ready;
    logic s;
    logic r;
    logic q_fb;
    logic busy;
    logic done;
    logic err;

    // Ideal latch plus an override used to force a stuck feedback.
    logic q_lat   = 1'b0;
    logic tie_en  = 1'b0;
    logic tie_val = 1'b0;

    int tests_run    = 0;
    int tests_failed = 0;

    sr_latch_driver #(
        .PULSE_W(2),
        .GAP_W  (1),
        .TIMEOUT(4),
        .CNT_W  (4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_valid(req_valid),
        .req_op   (req_op),
        .req_ready(req_ready),
        .s        (s),
        .r        (r),
        .q_fb     (q_fb),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    // Latch model: s sets, r resets, otherwise hold.
    always @(s or r) begin
        if (s)
            q_lat = 1'b1;
        else if (r)
            q_lat = 1'b0;
    end

    assign q_fb = tie_en ? tie_val : q_lat;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Present a request at the current negedge; returns in cycle 1 (after E0).
    task automatic send(input logic op);
        req_op    = op;
        req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    // Check a full command timeline from cycle 1 through its done cycle 4.
    // keep=1 leaves req_valid alone (back-to-back); otherwise it is dropped
    // after cycle 2.
    task automatic expect_cmd(input string tag, input logic op, input bit keep);
        for (int c = 1; c <= 4; c++) begin
            check({tag, "_s"},     s,         (op == 1'b1) && (c <= 2));
            check({tag, "_r"},     r,         (op == 1'b0) && (c <= 2));
            check({tag, "_done"},  done,      c == 4);
            check({tag, "_err"},   err,       1'b0);
            check({tag, "_busy"},  busy,      c <= 3);
            check({tag, "_ready"}, req_ready, c == 4);
            if (c == 4)
                check({tag, "_qfb"}, q_fb, op);
            if (c < 4) begin
                if (!keep && c == 2)
                    req_valid = 1'b0;
                @(negedge clk);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic cur;

        // Reset held with a pending request: everything idle.
        rst_n     = 1'b0;
        req_valid = 1'b1;
        req_op    = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_s",     s,         1'b0);
        check("rst_r",     r,         1'b0);
        check("rst_busy",  busy,      1'b0);
        check("rst_ready", req_ready, 1'b1);
        check("rst_done",  done,      1'b0);
        check("rst_err",   err,       1'b0);
        req_valid = 1'b0;
        rst_n     = 1'b1;
        @(negedge clk);
        check("post_rst_s", s, 1'b0);

        // Set then reset command, each with the nominal timing.
        send(1'b1);
        expect_cmd("set", 1'b1, 1'b0);
        send(1'b0);
        expect_cmd("clr", 1'b0, 1'b0);

        // Back-to-back: each new request accepted in the previous done cycle.
        for (int k = 0; k < 3; k++) begin
            req_op    = (k % 2 == 0);
            req_valid = 1'b1;
            @(posedge clk);
            @(negedge clk);
            expect_cmd("b2b", (k % 2 == 0), 1'b1);
        end
        req_valid = 1'b0;
        @(negedge clk);
        check("b2b_idle_done", done, 1'b0);

        // Timeout: feedback stuck low while setting.
        tie_en  = 1'b1;
        tie_val = 1'b0;
        send(1'b1);
        for (int c = 1; c <= 8; c++) begin
            check("to_s",     s,         c <= 2);
            check("to_r",     r,         1'b0);
            check("to_err",   err,       c == 7);
            check("to_done",  done,      1'b0);
            check("to_ready", req_ready, c >= 7);
            check("to_busy",  busy,      c <= 6);
            @(negedge clk);
        end
        tie_en = 1'b0;

        // Clear the latch, then a set with an ignored reset request while busy.
        send(1'b0);
        expect_cmd("pre_ign", 1'b0, 1'b0);
        @(negedge clk);
        send(1'b1);
        req_op    = 1'b0;
        req_valid = 1'b1;
        expect_cmd("ign", 1'b1, 1'b0);
        @(negedge clk);
        check("ign_after_busy", busy, 1'b0);
        check("ign_after_r",    r,    1'b0);

        // Redundant command: latch already set, set again.
        check("skip_pre_q", q_fb, 1'b1);
        send(1'b1);
`ifdef SR_SKIP_REDUNDANT_EN
        check("skip_done1", done, 1'b1);
        check("skip_busy1", busy, 1'b0);
        check("skip_s1",    s,    1'b0);
        for (int c = 2; c <= 4; c++) begin
            @(negedge clk);
            check("skip_s",    s,    1'b0);
            check("skip_done", done, 1'b0);
        end
`else
        expect_cmd("noskip", 1'b1, 1'b0);
`endif
        @(negedge clk);

        // Random traffic with occasional stuck feedback.
        for (int i = 0; i < 1000; i++) begin
            req_valid = 1'($urandom_range(0, 1));
            req_op    = 1'($urandom_range(0, 1));
            tie_en    = ($urandom_range(0, 7) == 0);
            tie_val   = 1'($urandom_range(0, 1));
            @(negedge clk);
            check("rnd_s_and_r",   s && r,    1'b0);
            check("rnd_done_err",  done && err, 1'b0);
        end
        req_valid = 1'b0;
        tie_en    = 1'b0;
        repeat (10) @(negedge clk);
        check("rnd_settle_busy", busy, 1'b0);

        // Asynchronous reset in the middle of a pulse.
        cur = q_fb;
        send(~cur);
        check("arst_pulse_on", (~cur) ? s : r, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_s",     s,         1'b0);
        check("arst_r",     r,         1'b0);
        check("arst_busy",  busy,      1'b0);
        check("arst_ready", req_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check("arst_no_done", done, 1'b0);
            check("arst_no_err",  err,  1'b0);
            check("arst_idle",    busy, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/sr_latch_driver.md
Name: sr_latch_driver

Overview:
- Clocked command front-end that drives the s/r inputs of an SR latch.
- Converts single set/reset requests into clean, width-controlled, mutually exclusive s or r pulses.
- Observes latch q as feedback and reports completion or timeout.
- Sits between control logic and any sr_latch instance; guarantees the forbidden s=r=1 input is never generated.

Parameters:
- PULSE_W, 2, cycles s or r is held high per command (>=1).
- GAP_W, 1, idle cycles with s=r=0 after the pulse, before feedback check (>=0).
- TIMEOUT, 4, max CHECK cycles waiting for q_fb to match before err (>=1).
- CNT_W, 4, counter width; must hold max(PULSE_W, GAP_W, TIMEOUT).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req_valid  input  1  command request.
- req_op  input  1  1 = set (drive s), 0 = reset (drive r).
- req_ready  output  1  high only in IDLE; transfer when req_valid && req_ready at clk edge.
- s  output  1  set drive to latch, registered.
- r  output  1  reset drive to latch, registered.
- q_fb  input  1  latch q output, treated as synchronous to clk.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse: q_fb matched the commanded value.
- err  output  1  one-cycle pulse: TIMEOUT expired without match.

Behaviour:
- Reset (rst_n=0, async): state=IDLE, s=0, r=0, done=0, err=0, busy=0, req_ready=1, counters=0, op register=0. Applies immediately mid-operation; an in-flight pulse is truncated, and no done/err is issued for the aborted command.
- FSM states: IDLE, PULSE, GAP, CHECK.
- IDLE: req_ready=1. On accept at edge E0: latch req_op, go to PULSE, cnt=PULSE_W-1.
  - req_valid while not in IDLE is ignored (req_ready=0); no queuing.
- PULSE: s=op, r=~op, both registered; high from E0 for exactly PULSE_W cycles.
  - At cnt==0: go to GAP (cnt=GAP_W-1), or to CHECK (cnt=TIMEOUT-1) if GAP_W=0.
- GAP: s=r=0 for exactly GAP_W cycles, then CHECK with cnt=TIMEOUT-1.
- CHECK: s=r=0. Each edge samples q_fb.
  - If q_fb==op: done=1 for one cycle, go to IDLE.
  - Else if cnt==0: err=1 for one cycle, go to IDLE.
  - Else decrement cnt.
- done and err are never high together. When either is asserted, the block is in IDLE and req_ready=1 in that same cycle, so back-to-back commands are accepted with no bubble.
- Latency with an ideal latch: done is high in cycle E0+PULSE_W+GAP_W+1. Err is high in cycle E0+PULSE_W+GAP_W+TIMEOUT.
- Invariant: s&&r==0 in every cycle, including across reset release.
- Counters never wrap; each state loads its count on entry.

Optional Feature:
- Macro SR_SKIP_REDUNDANT_EN.
- Defined: at acceptance, if q_fb already equals req_op, the block issues no pulse and does not enter PULSE/GAP/CHECK; done=1 in the cycle after E0, and the block stays IDLE.
- Undefined: every accepted command issues a full pulse regardless of q_fb.

Test Plan (PULSE_W=2, GAP_W=1, TIMEOUT=4, bench models an sr_latch on s/r->q_fb):
- Reset: hold rst_n=0 with req_valid=1 -> s=r=0, busy=0, req_ready=1, done=err=0. Assert rst_n low asynchronously mid-PULSE -> s drops before the next clk edge.
- Set command: accept op=1 at E0 -> s=1 for cycles 1-2, s=r=0 in cycle 3, done=1 in cycle 4, q_fb=1. Reset command then gives the same timing on r with q_fb=0.
- Back-to-back: hold req_valid=1, alternate op 1,0,1 -> each accepted in its done cycle, and q_fb toggles each time. Over 1000 random cycles, s&&r is never 1.
- Timeout: tie q_fb=0, send op=1 -> err=1 exactly in cycle 7, done stays 0, req_ready=1 in cycle 7.
- Ignored request: pulse req_valid with op=0 while busy -> no effect; s pulse completes unchanged.
- SR_SKIP_REDUNDANT_EN defined with q_fb=1: send op=1 -> s never asserts, done=1 in cycle 1. Macro undefined -> full 2-cycle s pulse, done in cycle 4.
